pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register for the OpenMIPS core, the successor to the fixed ID/EX latch. It carries an opaque payload bus of configurable width plus a valid bit and one sticky side-bit (the delay-slot flag for the next instruction). It supports two modes:
- MODE=0: classic stall-vector control with bubble insertion.
- MODE=1: 2-entry elastic skid buffer with a valid/ready handshake.
Flush and reset behave identically in both modes. It instantiates at ID/EX, EX/MEM and MEM/WB by changing STAGE and PAYLOAD_W.

Parameters:
PAYLOAD_W, 200, width of the payload bus (concatenated aluop/alusel/operands/wd/wreg/link/inst/pc/excepttype).
STALL_W, 6, width of the stall vector.
STAGE, 2, stall index of the upstream stage; downstream is STAGE+1 (STAGE+1 < STALL_W required).
MODE, 0, 0 = stall-vector register; 1 = 2-entry skid buffer.
NOP_PAYLOAD, 0, payload value driven for a bubble, empty buffer, reset or flush.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset; asynchronous, active-high
stall  input  STALL_W  pipeline stall vector, 1 = Stop (MODE=0 only)
flush  input  1  exception flush, synchronous
in_valid  input  1  upstream payload valid
in_payload  input  PAYLOAD_W  upstream payload
in_sticky  input  1  upstream sticky bit (next_inst_in_delayslot)
in_ready  output  1  buffer can accept (MODE=1); constant 1 in MODE=0
out_ready  input  1  downstream accepts head (MODE=1 only)
out_valid  output  1  out_payload is a real instruction
out_payload  output  PAYLOAD_W  registered payload to the next stage
out_sticky  output  1  registered sticky bit
occupancy  output  2  entries held (0..2); MODE=0 reports 0 or 1

Behaviour:
- Reset (async, rst=1): out_valid=0, out_payload=NOP_PAYLOAD, out_sticky=0, occupancy=0, both skid entries cleared. Takes effect immediately, mid-operation included. First update is at the first rising edge after rst falls.
- flush=1 at an edge (both modes): same values as reset. Flush has priority over every stall and handshake condition.
- MODE=0, per edge, in priority order after rst/flush:
  - stall[STAGE]=1 and stall[STAGE+1]=0: bubble. out_payload=NOP_PAYLOAD, out_valid=0, out_sticky held (not cleared).
  - stall[STAGE]=0: load. out_payload=in_payload, out_valid=in_valid, out_sticky=in_sticky.
  - Otherwise: hold all outputs.
  - Latency is 1 cycle. occupancy equals out_valid.
- MODE=1 (stall ignored):
  - in_ready = (count != 2), registered-derived with no combinational path from out_ready.
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - Entry 0 is the head. out_payload = head, or NOP_PAYLOAD when count=0. out_valid = (count != 0).
  - count 0, push: head loaded; out_valid next cycle (1-cycle latency).
  - count 1, push & pop: head replaced by the new payload; count stays 1.
  - count 1, push only: entry 1 loaded; count=2; in_ready drops next cycle.
  - count 2, pop: entry 1 shifts to head; count=1.
  - count 2: no push is possible. A pop alone reopens in_ready the next cycle.
  - out_sticky is the sticky bit of the head, captured with its payload on push. It is 0 when empty.
  - Order is preserved; no entry is ever dropped or duplicated.
- Sticky semantics: a branch sets in_sticky. The flag must survive a bubble so the delay-slot instruction, issued after the stall, still sees it.

Test Plan:
1. MODE=0: rst pulse mid-cycle while out_valid=1 -> outputs go immediately to NOP_PAYLOAD, out_valid=0, out_sticky=0, without waiting for a clock.
2. MODE=0, STAGE=2: in_payload=0xA5.., in_valid=1, stall=6'b000000 -> next edge out_payload=0xA5.., out_valid=1. Then stall=6'b000111 -> NOP_PAYLOAD and out_valid=0, with out_sticky still 1 if previously loaded 1.
3. MODE=0: stall=6'b001111 for 3 cycles with payload P loaded -> out_payload=P for all 3 cycles. Then stall=0 with new payload Q -> Q appears one edge later.
4. MODE=0: flush=1 together with stall[2]=0 and in_valid=1 -> flush wins; out_valid=0, out_sticky=0.
5. MODE=1: push 1,2,3 on consecutive cycles with out_ready=0 -> occupancy 1,2,2, in_ready=0 from cycle 3 and payload 3 not accepted. Then out_ready=1 -> outputs 1 then 2 in order, occupancy 1 then 0.
6. MODE=1: count=1 with simultaneous push of X and pop -> occupancy stays 1, head=X next cycle. flush while count=2 -> occupancy=0, out_valid=0, in_ready=1 next cycle.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: either a stall-vector latch with
// bubble insertion (MODE=0) or a 2-entry elastic skid buffer (MODE=1).
module pipe_stage_reg #(
  parameter int unsigned           PAYLOAD_W   = 200,
  parameter int unsigned           STALL_W     = 6,
  parameter int unsigned           STAGE       = 2,
  parameter int unsigned           MODE        = 0,
  parameter logic [PAYLOAD_W-1:0]  NOP_PAYLOAD = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STALL_W-1:0]   stall,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 in_sticky,
  output logic                 in_ready,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 out_sticky,
  output logic [1:0]           occupancy
);

  if (STAGE + 1 >= STALL_W) begin : gBadStage
    $error("pipe_stage_reg: STAGE+1 must index inside the stall vector");
  end

  if (MODE == 0) begin : gStallReg
    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic                 valid_q, valid_d;
    logic                 sticky_q, sticky_d;
    logic                 stallHere, stallNext;
    logic                 unusedMode0;

    assign stallHere   = stall[STAGE];
    assign stallNext   = stall[STAGE+1];
    assign unusedMode0 = ^{out_ready, stall};

    // Upstream stalled while downstream runs: emit a bubble, but keep the
    // delay-slot flag so the instruction issued after the stall still sees it.
    always_comb begin
      payload_d = payload_q;
      valid_d   = valid_q;
      sticky_d  = sticky_q;
      if (flush) begin
        payload_d = NOP_PAYLOAD;
        valid_d   = 1'b0;
        sticky_d  = 1'b0;
      end else if (stallHere && !stallNext) begin
        payload_d = NOP_PAYLOAD;
        valid_d   = 1'b0;
      end else if (!stallHere) begin
        payload_d = in_payload;
        valid_d   = in_valid;
        sticky_d  = in_sticky;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        payload_q <= NOP_PAYLOAD;
        valid_q   <= 1'b0;
        sticky_q  <= 1'b0;
      end else begin
        payload_q <= payload_d;
        valid_q   <= valid_d;
        sticky_q  <= sticky_d;
      end
    end

    assign in_ready    = 1'b1;
    assign out_valid   = valid_q;
    assign out_payload = payload_q;
    assign out_sticky  = sticky_q;
    assign occupancy   = {1'b0, valid_q};
  end else begin : gSkidBuf
    logic [PAYLOAD_W-1:0] head_q, head_d;
    logic [PAYLOAD_W-1:0] tail_q, tail_d;
    logic                 headSticky_q, headSticky_d;
    logic                 tailSticky_q, tailSticky_d;
    logic [1:0]           count_q, count_d;
    logic                 push, pop;
    logic                 unusedMode1;

    // in_ready comes only from the registered count, never from out_ready.
    assign push        = in_valid && (count_q != 2'd2);
    assign pop         = (count_q != 2'd0) && out_ready;
    assign unusedMode1 = ^stall;

    // Vacated entries are refilled with NOP so the head register can drive
    // out_payload directly, already showing NOP when the buffer is empty.
    always_comb begin
      head_d       = head_q;
      tail_d       = tail_q;
      headSticky_d = headSticky_q;
      tailSticky_d = tailSticky_q;
      count_d      = count_q;
      if (flush) begin
        head_d       = NOP_PAYLOAD;
        tail_d       = NOP_PAYLOAD;
        headSticky_d = 1'b0;
        tailSticky_d = 1'b0;
        count_d      = 2'd0;
      end else begin
        case (count_q)
          2'd0: begin
            if (push) begin
              head_d       = in_payload;
              headSticky_d = in_sticky;
              count_d      = 2'd1;
            end
          end
          2'd1: begin
            if (push && pop) begin
              head_d       = in_payload;
              headSticky_d = in_sticky;
            end else if (push) begin
              tail_d       = in_payload;
              tailSticky_d = in_sticky;
              count_d      = 2'd2;
            end else if (pop) begin
              head_d       = NOP_PAYLOAD;
              headSticky_d = 1'b0;
              count_d      = 2'd0;
            end
          end
          2'd2: begin
            if (pop) begin
              head_d       = tail_q;
              headSticky_d = tailSticky_q;
              tail_d       = NOP_PAYLOAD;
              tailSticky_d = 1'b0;
              count_d      = 2'd1;
            end
          end
          default: begin
            head_d       = NOP_PAYLOAD;
            tail_d       = NOP_PAYLOAD;
            headSticky_d = 1'b0;
            tailSticky_d = 1'b0;
            count_d      = 2'd0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        head_q       <= NOP_PAYLOAD;
        tail_q       <= NOP_PAYLOAD;
        headSticky_q <= 1'b0;
        tailSticky_q <= 1'b0;
        count_q      <= 2'd0;
      end else begin
        head_q       <= head_d;
        tail_q       <= tail_d;
        headSticky_q <= headSticky_d;
        tailSticky_q <= tailSticky_d;
        count_q      <= count_d;
      end
    end

    assign in_ready    = (count_q != 2'd2);
    assign out_valid   = (count_q != 2'd0);
    assign out_payload = head_q;
    assign out_sticky  = headSticky_q;
    assign occupancy   = count_q;
  end

endmodule
